// File: rtl/mc_ctrl_fsm_pkg.sv
// rtl/mc_ctrl_fsm_pkg.sv - state encodings, opcode/funct and select-code constants for the control sequencer
package mc_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_DCD = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    // One bit per supported instruction; all-zero means illegal.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
    } iclass_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - IR fields, handshakes and datapath controls between sequencer and datapath (instret with MC_PERF_CNT_EN)
interface mc_ctrl_fsm_if
`ifdef MC_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ();

    logic [5:0] op;
    logic [5:0] funct;
    logic       alu_zero;
    logic       imem_rdy;
    logic       dmem_rdy;
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_we;
    logic       mem_re;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [1:0] npc_sel;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       err;
`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] instret;
`endif

    modport master (
        input  op, funct, alu_zero, imem_rdy, dmem_rdy,
        output pc_we, ir_we, reg_we, mem_we, mem_re,
        output alu_src, reg_dst, wd_sel, npc_sel, ext_op, alu_op, err
`ifdef MC_PERF_CNT_EN
        , output instret
`endif
    );

    modport slave (
        output op, funct, alu_zero, imem_rdy, dmem_rdy,
        input  pc_we, ir_we, reg_we, mem_we, mem_re,
        input  alu_src, reg_dst, wd_sel, npc_sel, ext_op, alu_op, err
`ifdef MC_PERF_CNT_EN
        , input instret
`endif
    );

endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// rtl/mc_ctrl_fsm_decode.sv - combinational op/funct to one-hot instruction class plus illegal flag
module mc_ctrl_fsm_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output iclass_t    cls_o,
    output logic       illegal_o
);

    // Classify the instruction word; anything unrecognised leaves every class bit clear.
    always_comb begin
        cls_o = '0;
        case (op_i)
            OP_RTYPE: begin
                cls_o.addu = (funct_i == FN_ADDU);
                cls_o.subu = (funct_i == FN_SUBU);
            end
            OP_ORI:  cls_o.ori = 1'b1;
            OP_LW:   cls_o.lw  = 1'b1;
            OP_SW:   cls_o.sw  = 1'b1;
            OP_BEQ:  cls_o.beq = 1'b1;
            OP_LUI:  cls_o.lui = 1'b1;
            OP_J:    cls_o.j   = 1'b1;
            OP_JAL:  cls_o.jal = 1'b1;
            default: cls_o = '0;
        endcase
        illegal_o = (cls_o == '0);
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS-subset control sequencer (IF/DCD/EXE/MEM/WB/ERR), MC_PERF_CNT_EN adds instret
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.master bus
);

    state_e  state_q, state_d;
    iclass_t cls;
    logic    illegal;
    logic    pc_we_r, ir_we_r, reg_we_r, mem_we_r, mem_re_r;
    logic    alu_src;
    logic [1:0] reg_dst, wd_sel, npc_sel, ext_op;
    logic [2:0] alu_op;
`ifdef MC_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] instret_q;
`endif

    mc_ctrl_fsm_decode u_decode (
        .op_i      (bus.op),
        .funct_i   (bus.funct),
        .cls_o     (cls),
        .illegal_o (illegal)
    );

    // State register; reset restarts at instruction fetch and clears the sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IF;
        else        state_q <= state_d;
    end

    // Next state plus raw strobes and selects decoded from state and instruction class.
    always_comb begin
        state_d  = state_q;
        pc_we_r  = 1'b0;
        ir_we_r  = 1'b0;
        reg_we_r = 1'b0;
        mem_we_r = 1'b0;
        mem_re_r = 1'b0;
        alu_src  = 1'b0;
        reg_dst  = RD_RT;
        wd_sel   = WD_ALU;
        npc_sel  = NPC_PC4;
        ext_op   = EXT_ZERO;
        alu_op   = ALU_ADD;
`ifdef MC_PERF_CNT_EN
        retire   = 1'b0;
`endif
        // Instruction selects stay constant from EXE through WB so the datapath sees no glitches.
        if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
            if (cls.addu || cls.subu) begin
                reg_dst = RD_RD;
                alu_op  = cls.subu ? ALU_SUB : ALU_ADD;
            end
            if (cls.ori) begin
                alu_src = 1'b1;
                ext_op  = EXT_ZERO;
                alu_op  = ALU_OR;
            end
            if (cls.lui) begin
                alu_src = 1'b1;
                ext_op  = EXT_LUI;
            end
            if (cls.lw || cls.sw) begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
            end
            if (cls.lw)  wd_sel = WD_MEM;
            if (cls.beq) begin
                alu_op  = ALU_SUB;
                npc_sel = NPC_BR;
            end
        end
        case (state_q)
            S_IF: begin
                pc_we_r = bus.imem_rdy;
                ir_we_r = bus.imem_rdy;
                if (bus.imem_rdy) state_d = S_DCD;
            end
            S_DCD: begin
                if (cls.j || cls.jal) begin
                    pc_we_r = 1'b1;
                    npc_sel = NPC_JMP;
                    state_d = S_IF;
`ifdef MC_PERF_CNT_EN
                    retire  = 1'b1;
`endif
                    if (cls.jal) begin
                        reg_we_r = 1'b1;
                        reg_dst  = RD_RA;
                        wd_sel   = WD_PC4;
                    end
                end else if (illegal) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (cls.beq) begin
                    pc_we_r = bus.alu_zero;
                    state_d = S_IF;
`ifdef MC_PERF_CNT_EN
                    retire  = 1'b1;
`endif
                end else if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_re_r = cls.lw;
                mem_we_r = cls.sw;
                if (bus.dmem_rdy) begin
                    state_d = cls.sw ? S_IF : S_WB;
`ifdef MC_PERF_CNT_EN
                    retire  = cls.sw;
`endif
                end
            end
            S_WB: begin
                reg_we_r = 1'b1;
                state_d  = S_IF;
`ifdef MC_PERF_CNT_EN
                retire   = 1'b1;
`endif
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IF;
        endcase
    end

`ifdef MC_PERF_CNT_EN
    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (!rst_n)      instret_q <= '0;
        else if (retire) instret_q <= instret_q + 1'b1;
    end
    assign bus.instret = instret_q;
`endif

    // Strobes are gated by rst_n so a reset aborts any pending write in the same cycle.
    assign bus.pc_we   = pc_we_r  & rst_n;
    assign bus.ir_we   = ir_we_r  & rst_n;
    assign bus.reg_we  = reg_we_r & rst_n;
    assign bus.mem_we  = mem_we_r & rst_n;
    assign bus.mem_re  = mem_re_r & rst_n;
    assign bus.alu_src = alu_src;
    assign bus.reg_dst = reg_dst;
    assign bus.wd_sel  = wd_sel;
    assign bus.npc_sel = npc_sel;
    assign bus.ext_op  = ext_op;
    assign bus.alu_op  = alu_op;
    assign bus.err     = (state_q == S_ERR);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed cycle-by-cycle bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected output word: {pc_we,ir_we,reg_we,mem_we,mem_re,alu_src,reg_dst,wd_sel,npc_sel,ext_op,alu_op,err}
    function automatic logic [17:0] o(input logic pc, input logic ir, input logic rw, input logic mw,
                                      input logic mr, input logic as, input logic [1:0] rd,
                                      input logic [1:0] wd, input logic [1:0] np, input logic [1:0] ex,
                                      input logic [2:0] al, input logic er);
        return {pc, ir, rw, mw, mr, as, rd, wd, np, ex, al, er};
    endfunction

    function automatic logic [17:0] observed();
        return {bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_we, bus.mem_re, bus.alu_src,
                bus.reg_dst, bus.wd_sel, bus.npc_sel, bus.ext_op, bus.alu_op, bus.err};
    endfunction

    task automatic drive(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic az, input logic ir, input logic dr);
        rst_n        = rst;
        bus.op       = op;
        bus.funct    = fn;
        bus.alu_zero = az;
        bus.imem_rdy = ir;
        bus.dmem_rdy = dr;
    endtask

    // One clock: apply inputs, check outputs and current state mid-cycle, then advance.
    task automatic cyc(input string tag, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic az, input logic ir, input logic dr,
                       input logic [17:0] exp, input state_e st);
        drive(rst, op, fn, az, ir, dr);
        #1;
        chk({tag, "/out"}, 32'(observed()), 32'(exp));
        chk({tag, "/st"}, 32'(dut.state_q), 32'(st));
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n, input logic [5:0] op, input logic [5:0] fn, input logic az);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, op, fn, az, 1'b1, 1'b1);
            @(posedge clk);
            #1;
        end
    endtask

    logic [17:0] z;
    logic [17:0] fetch;

    initial begin
        z     = '0;
        fetch = o(1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        drive(1'b0, OP_RTYPE, FN_ADDU, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        cyc("rst", 0, OP_RTYPE, FN_ADDU, 0, 1, 1, z, S_IF);
`ifdef MC_PERF_CNT_EN
        chk("instret_rst", bus.instret, 32'd0);
`endif

        // addu, no waits
        cyc("addu_if",  1, OP_RTYPE, FN_ADDU, 0, 1, 0, fetch, S_IF);
        cyc("addu_dcd", 1, OP_RTYPE, FN_ADDU, 0, 0, 0, z, S_DCD);
        cyc("addu_exe", 1, OP_RTYPE, FN_ADDU, 0, 0, 0, o(0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b000, 0), S_EXE);
        cyc("addu_wb",  1, OP_RTYPE, FN_ADDU, 0, 0, 0, o(0,0,1,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b000, 0), S_WB);

        // subu
        cyc("subu_if",  1, OP_RTYPE, FN_SUBU, 0, 1, 0, fetch, S_IF);
        cyc("subu_dcd", 1, OP_RTYPE, FN_SUBU, 0, 0, 0, z, S_DCD);
        cyc("subu_exe", 1, OP_RTYPE, FN_SUBU, 0, 0, 0, o(0,0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b001, 0), S_EXE);
        cyc("subu_wb",  1, OP_RTYPE, FN_SUBU, 0, 0, 0, o(0,0,1,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b001, 0), S_WB);

        // imem wait then ori
        cyc("ori_wait", 1, OP_ORI, 6'h00, 0, 0, 0, z, S_IF);
        cyc("ori_if",   1, OP_ORI, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("ori_dcd",  1, OP_ORI, 6'h00, 0, 0, 0, z, S_DCD);
        cyc("ori_exe",  1, OP_ORI, 6'h00, 0, 0, 0, o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0), S_EXE);
        cyc("ori_wb",   1, OP_ORI, 6'h00, 0, 0, 0, o(0,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b010, 0), S_WB);

        // lui
        cyc("lui_if",  1, OP_LUI, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("lui_dcd", 1, OP_LUI, 6'h00, 0, 0, 0, z, S_DCD);
        cyc("lui_exe", 1, OP_LUI, 6'h00, 0, 0, 0, o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b10, 3'b000, 0), S_EXE);
        cyc("lui_wb",  1, OP_LUI, 6'h00, 0, 0, 0, o(0,0,1,0,0,1, 2'b00,2'b00,2'b00,2'b10, 3'b000, 0), S_WB);

        // lw with two dmem wait cycles: 7 cycles total
        cyc("lw_if",   1, OP_LW, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("lw_dcd",  1, OP_LW, 6'h00, 0, 0, 0, z, S_DCD);
        cyc("lw_exe",  1, OP_LW, 6'h00, 0, 0, 0, o(0,0,0,0,0,1, 2'b00,2'b01,2'b00,2'b01, 3'b000, 0), S_EXE);
        cyc("lw_mem0", 1, OP_LW, 6'h00, 0, 0, 0, o(0,0,0,0,1,1, 2'b00,2'b01,2'b00,2'b01, 3'b000, 0), S_MEM);
        cyc("lw_mem1", 1, OP_LW, 6'h00, 0, 0, 0, o(0,0,0,0,1,1, 2'b00,2'b01,2'b00,2'b01, 3'b000, 0), S_MEM);
        cyc("lw_mem2", 1, OP_LW, 6'h00, 0, 0, 1, o(0,0,0,0,1,1, 2'b00,2'b01,2'b00,2'b01, 3'b000, 0), S_MEM);
        cyc("lw_wb",   1, OP_LW, 6'h00, 0, 0, 0, o(0,0,1,0,0,1, 2'b00,2'b01,2'b00,2'b01, 3'b000, 0), S_WB);

        // sw, no waits
        cyc("sw_if",  1, OP_SW, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("sw_dcd", 1, OP_SW, 6'h00, 0, 0, 0, z, S_DCD);
        cyc("sw_exe", 1, OP_SW, 6'h00, 0, 0, 0, o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0), S_EXE);
        cyc("sw_mem", 1, OP_SW, 6'h00, 0, 0, 1, o(0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0), S_MEM);

        // beq not taken, then taken
        cyc("beq0_if",  1, OP_BEQ, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("beq0_dcd", 1, OP_BEQ, 6'h00, 0, 0, 0, z, S_DCD);
        cyc("beq0_exe", 1, OP_BEQ, 6'h00, 0, 0, 0, o(0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b001, 0), S_EXE);
        cyc("beq1_if",  1, OP_BEQ, 6'h00, 1, 1, 0, fetch, S_IF);
        cyc("beq1_dcd", 1, OP_BEQ, 6'h00, 1, 0, 0, z, S_DCD);
        cyc("beq1_exe", 1, OP_BEQ, 6'h00, 1, 0, 0, o(1,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b001, 0), S_EXE);

        // jal then j
        cyc("jal_if",  1, OP_JAL, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("jal_dcd", 1, OP_JAL, 6'h00, 0, 0, 0, o(1,0,1,0,0,0, 2'b10,2'b10,2'b10,2'b00, 3'b000, 0), S_DCD);
        cyc("j_if",    1, OP_J, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("j_dcd",   1, OP_J, 6'h00, 0, 0, 0, o(1,0,0,0,0,0, 2'b00,2'b00,2'b10,2'b00, 3'b000, 0), S_DCD);

        // illegal opcode: sticky error until reset
        cyc("ill_if",  1, 6'h3F, 6'h00, 1, 1, 1, fetch, S_IF);
        cyc("ill_dcd", 1, 6'h3F, 6'h00, 1, 1, 1, z, S_DCD);
        for (int i = 0; i < 10; i++)
            cyc($sformatf("ill_err%0d", i), 1, 6'h3F, 6'h00, 1, 1, 1, o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1), S_ERR);
        cyc("ill_rst",  0, 6'h3F, 6'h00, 1, 1, 1, o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1), S_ERR);
        cyc("ill_idle", 1, 6'h3F, 6'h00, 0, 0, 0, z, S_IF);

        // illegal funct under R-type opcode
        cyc("fn_if",   1, OP_RTYPE, 6'h20, 0, 1, 0, fetch, S_IF);
        cyc("fn_dcd",  1, OP_RTYPE, 6'h20, 0, 0, 0, z, S_DCD);
        cyc("fn_err",  1, OP_RTYPE, 6'h20, 0, 0, 0, o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1), S_ERR);
        cyc("fn_rst",  0, OP_RTYPE, 6'h20, 0, 0, 0, o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1), S_ERR);

        // reset in IF with imem ready: fetch strobes gated
        cyc("rif_rst", 0, OP_SW, 6'h00, 0, 1, 0, z, S_IF);

        // sw abandoned by reset while waiting in MEM
        cyc("swr_if",   1, OP_SW, 6'h00, 0, 1, 0, fetch, S_IF);
        cyc("swr_dcd",  1, OP_SW, 6'h00, 0, 0, 0, z, S_DCD);
        cyc("swr_exe",  1, OP_SW, 6'h00, 0, 0, 0, o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0), S_EXE);
        cyc("swr_mem",  1, OP_SW, 6'h00, 0, 0, 0, o(0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0), S_MEM);
        cyc("swr_rst",  0, OP_SW, 6'h00, 0, 0, 0, o(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0), S_MEM);
        cyc("swr_idle", 1, OP_SW, 6'h00, 0, 0, 0, z, S_IF);
`ifdef MC_PERF_CNT_EN
        chk("instret_after_rst", bus.instret, 32'd0);
`endif

        // five mixed instructions, zero waits: 4+5+4+3+2 cycles
        step_n(4, OP_RTYPE, FN_ADDU, 1'b0);
        step_n(5, OP_LW, 6'h00, 1'b0);
        step_n(4, OP_SW, 6'h00, 1'b0);
        step_n(3, OP_BEQ, 6'h00, 1'b1);
        step_n(2, OP_J, 6'h00, 1'b0);
        chk("mix_state", 32'(dut.state_q), 32'(S_IF));
`ifdef MC_PERF_CNT_EN
        chk("instret_mix", bus.instret, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
